// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: a word-addressed instruction RAM read one bundle
// (FETCH_WIDTH words) per cycle into an in-flight register, then queued in a
// small FIFO of bundles for the decode stage. Supports redirect flush and a
// loader write port.
module inst_fetch_buffer #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           RAM_DEPTH   = 256,
  parameter int unsigned           FETCH_WIDTH = 2,
  parameter int unsigned           QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter string                 MEM_FILE    = ""
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              redirect_valid,
  input  logic [ADDR_WIDTH-1:0]             redirect_pc,
  input  logic                              wr_en,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              deq_ready,
  output logic                              deq_valid,
  output logic [ADDR_WIDTH-1:0]             deq_pc,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] deq_inst,
  output logic [$clog2(QUEUE_DEPTH):0]      occupancy
);

  localparam int unsigned IDX_W    = $clog2(RAM_DEPTH);
  localparam int unsigned PTR_W    = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned BUNDLE_W = FETCH_WIDTH * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4 * FETCH_WIDTH);

  // Instruction storage
  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  // Fetch state
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_inflight_valid;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;
  logic [BUNDLE_W-1:0]   r_inflight_inst;

  // Bundle queue
  logic [ADDR_WIDTH-1:0] r_q_pc   [QUEUE_DEPTH];
  logic [BUNDLE_W-1:0]   r_q_inst [QUEUE_DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic [IDX_W-1:0]      w_wr_idx;
  logic [BUNDLE_W-1:0]   w_rd_bundle;
  logic                  w_issue;
  logic                  w_enq;
  logic                  w_deq;
  logic [CNT_W-1:0]      w_count_d;
  logic                  w_unused;

  // Low address bits only select bytes within a word; high bits alias modulo RAM_DEPTH.
  assign w_unused = ^{wr_addr, redirect_pc[1:0]};
  assign w_wr_idx = wr_addr[IDX_W+1:2];

  // Loader write port; reset has priority and memory itself is never cleared.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  // Bundle read: slot k takes word ((pc>>2)+k) mod RAM_DEPTH, wrapping across the top.
  always_comb begin
    logic [IDX_W-1:0] idx;
    w_rd_bundle = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      idx = r_fetch_pc[IDX_W+1:2] + IDX_W'(k);
      w_rd_bundle[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[idx];
    end
  end

  // Issue only when the in-flight bundle is guaranteed a queue slot next edge.
  always_comb begin
    w_issue = 1'b0;
    if (!redirect_valid &&
        (({1'b0, r_count} + (CNT_W+1)'(r_inflight_valid)) < (CNT_W+1)'(QUEUE_DEPTH))) begin
      w_issue = 1'b1;
    end
  end

  // Fetch pc and in-flight register; redirect drops the in-flight bundle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc       <= RESET_PC;
      r_inflight_valid <= 1'b0;
      r_inflight_pc    <= '0;
      r_inflight_inst  <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc       <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      r_inflight_valid <= 1'b0;
    end else begin
      r_inflight_valid <= w_issue;
      if (w_issue) begin
        r_inflight_pc   <= r_fetch_pc;
        r_inflight_inst <= w_rd_bundle;
        r_fetch_pc      <= r_fetch_pc + PC_STEP;
      end
    end
  end

  // Queue handshake and next occupancy.
  always_comb begin
    w_enq     = r_inflight_valid && !redirect_valid;
    w_deq     = deq_valid && deq_ready;
    w_count_d = r_count;
    if (w_enq && !w_deq) begin
      w_count_d = r_count + CNT_W'(1);
    end else if (!w_enq && w_deq) begin
      w_count_d = r_count - CNT_W'(1);
    end
  end

  // Queue storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && w_enq) begin
      r_q_pc[r_tail]   <= r_inflight_pc;
      r_q_inst[r_tail] <= r_inflight_inst;
    end
  end

  // Queue pointers and count; pointers wrap naturally since depth is a power of 2.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_deq) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= w_count_d;
    end
  end

  // Head bundle outputs, forced to zero when the queue is empty.
  always_comb begin
    deq_valid = (r_count != '0);
    occupancy = r_count;
    deq_pc    = '0;
    deq_inst  = '0;
    if (deq_valid) begin
      deq_pc   = r_q_pc[r_head];
      deq_inst = r_q_inst[r_head];
    end
  end

endmodule
